// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states and the
// captured context of an in-flight load.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    typedef struct packed {
        size_e      size;
        logic       uns;
        logic [4:0] rd;
    } load_ctx_t;

    localparam int CNT_W = 3;

    function automatic int size_bytes(size_e s);
        return 1 << int'(s);
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Pulls the addressed lane out of a BRAM word and sign/zero extends it.
module lsu_extend
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]           rdata,
    input  logic [$clog2(WIDTH/8)-1:0] offset,
    input  size_e                      size,
    input  logic                       uns,
    output logic [WIDTH-1:0]           data
);
    logic [WIDTH-1:0] lane;
    logic             sign;
    int               nbits;

    always_comb begin
        lane  = rdata >> {offset, 3'b000};
        nbits = size_bytes(size) * 8;
        if (nbits > WIDTH) nbits = WIDTH;
        sign = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i == nbits - 1) sign = lane[i] & ~uns;
        end
        for (int i = 0; i < WIDTH; i++) begin
            data[i] = (i < nbits) ? lane[i] : sign;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of a fixed-latency BRAM.
// Stores and misaligned accesses retire at acceptance; loads block until data returns.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [1:0]         req_size,
    input  logic               req_unsigned,
    input  logic [WIDTH-1:0]   req_addr,
    input  logic [WIDTH-1:0]   req_wdata,
    input  logic [4:0]         req_rd,
    output logic               resp_valid,
    output logic [WIDTH-1:0]   resp_data,
    output logic [4:0]         resp_rd,
    output logic               misaligned,
    output logic               stall,
    output logic               dm_en,
    output logic [WIDTH/8-1:0] dm_we,
    output logic [WIDTH-1:0]   dm_addr,
    output logic [WIDTH-1:0]   dm_wdata,
    input  logic [WIDTH-1:0]   dm_rdata
);
    localparam int NB   = WIDTH / 8;
    localparam int OFFS = $clog2(NB);

    state_e           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    load_ctx_t        ctx;
    logic [OFFS-1:0]  ctx_off;

    size_e              sz;
    logic [OFFS-1:0]    offset, amask;
    logic [NB:0]        lane_bit;
    logic [NB-1:0]      lanes;
    logic [NB-1:0][7:0] wbytes;
    logic               acc, bad, load_go, done;
    logic [WIDTH-1:0]   ext_data;

    always_comb begin
        sz       = size_e'(req_size);
        offset   = req_addr[OFFS-1:0];
        amask    = OFFS'(size_bytes(sz) - 1);
        bad      = (sz == SZ_D && WIDTH != 64) || ((offset & amask) != '0);
        req_ready = rst || (state == IDLE);
        stall    = req_valid && !req_ready;
        acc      = req_valid && req_ready && !rst;
        // Full-width mask wraps to all ones because the top bit falls off.
        lane_bit = (NB+1)'(1) << size_bytes(sz);
        lanes    = NB'(lane_bit - (NB+1)'(1));
        for (int i = 0; i < NB; i++) begin
            wbytes[i] = req_wdata[8*(i & int'(amask)) +: 8];
        end
        dm_en    = acc && !bad;
        dm_we    = (dm_en && req_we) ? (lanes << offset) : '0;
        dm_addr  = {req_addr[WIDTH-1:OFFS], {OFFS{1'b0}}};
        dm_wdata = wbytes;
        load_go  = dm_en && !req_we;
        done     = (state == WAIT) && (cnt == CNT_W'(1));
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (load_go) begin
                    state_next = WAIT;
                    cnt_next   = CNT_W'(RD_LATENCY);
                end
            end
            WAIT: begin
                cnt_next = cnt - CNT_W'(1);
                if (done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            resp_valid <= 1'b0;
            misaligned <= 1'b0;
            resp_data  <= '0;
            resp_rd    <= '0;
            ctx        <= '0;
            ctx_off    <= '0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            resp_valid <= done;
            misaligned <= acc && bad;
            if (load_go) begin
                ctx     <= '{size: sz, uns: req_unsigned, rd: req_rd};
                ctx_off <= offset;
            end
            if (done) begin
                resp_data <= ext_data;
                resp_rd   <= ctx.rd;
            end
        end
    end

    lsu_extend #(.WIDTH(WIDTH)) u_extend (
        .rdata  (dm_rdata),
        .offset (ctx_off),
        .size   (ctx.size),
        .uns    (ctx.uns),
        .data   (ext_data)
    );

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit (WIDTH=32, RD_LATENCY=2): byte-addressed reference
// memory plus cycle-scheduled expectations, directed cases and random traffic.
module tb_load_store_unit;
    localparam int W = 32;
    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        req_ready, resp_valid, misaligned, stall, dm_en;
    logic [31:0] resp_data, dm_addr, dm_wdata;
    logic [31:0] dm_rdata = '0;
    logic [4:0]  resp_rd;
    logic [3:0]  dm_we;

    load_store_unit #(.WIDTH(W), .RD_LATENCY(L)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd),
        .misaligned(misaligned), .stall(stall),
        .dm_en(dm_en), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0, n_fail = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] mem_init(input int a);
        return 8'((a * 37 + 11) ^ (a >> 3));
    endfunction

    // External BRAM: ports latched mid-cycle, data returned L cycles after enable.
    logic [31:0] bram [0:127];
    logic        en_s = 1'b0;
    logic [3:0]  we_s = '0;
    logic [31:0] addr_s = '0, wd_s = '0, p1 = '0;

    always @(negedge clk) begin
        en_s   <= dm_en;
        we_s   <= dm_we;
        addr_s <= dm_addr;
        wd_s   <= dm_wdata;
    end

    initial begin
        for (int w = 0; w < 128; w++)
            bram[w] = {mem_init(4*w+3), mem_init(4*w+2), mem_init(4*w+1), mem_init(4*w)};
        forever begin
            @(posedge clk);
            if (en_s) begin
                p1 <= bram[addr_s[8:2]];
                for (int b = 0; b < 4; b++)
                    if (we_s[b]) bram[addr_s[8:2]][8*b +: 8] = wd_s[8*b +: 8];
            end
            dm_rdata <= p1;
        end
    end

    // Reference model: the unit is free again at free_at; events are scheduled by cycle.
    logic [7:0]  ref_mem [0:511];
    int          free_at = 0, resp_cyc = -1, mis_cyc = -1;
    logic [31:0] resp_val = '0, last_data = '0;
    logic [4:0]  resp_tag = '0, last_rd = '0;

    initial begin : model
        logic        exp_ready, acc, bad, exp_en;
        int          nb, a;
        logic [63:0] v;
        logic [31:0] exp_wd;
        for (int i = 0; i < 512; i++) ref_mem[i] = mem_init(i);
        forever begin
            @(negedge clk);
            if (chk_en) begin
                exp_ready = rst || (cyc >= free_at);
                acc = !rst && req_valid && exp_ready;
                chk("req_ready", req_ready, exp_ready);
                chk("stall", stall, req_valid && !exp_ready);
                if (cyc == resp_cyc) begin
                    last_data = resp_val;
                    last_rd   = resp_tag;
                end
                chk("resp_valid", resp_valid, cyc == resp_cyc);
                chk("resp_data", resp_data, last_data);
                chk("resp_rd", resp_rd, last_rd);
                chk("misaligned", misaligned, cyc == mis_cyc);
                nb = 1 << req_size;
                a = int'(req_addr);
                bad = (req_size == 2'd3) || ((a % nb) != 0);
                exp_en = acc && !bad;
                chk("dm_en", dm_en, exp_en);
                chk("dm_we", dm_we, (exp_en && req_we) ? (((1 << nb) - 1) << (a % 4)) : 0);
                if (exp_en) chk("dm_addr", dm_addr, 32'(a - a % 4));
                if (exp_en && req_we) begin
                    for (int b = 0; b < 4; b++) exp_wd[8*b +: 8] = req_wdata[8*(b % nb) +: 8];
                    chk("dm_wdata", dm_wdata, exp_wd);
                end
                if (rst) begin
                    resp_cyc  = -1;
                    mis_cyc   = -1;
                    last_data = '0;
                    last_rd   = '0;
                    free_at   = cyc + 1;
                end else if (acc) begin
                    if (bad) mis_cyc = cyc + 1;
                    else if (req_we) begin
                        for (int k = 0; k < nb; k++) ref_mem[a+k] = req_wdata[8*k +: 8];
                    end else begin
                        v = '0;
                        for (int k = 0; k < nb; k++) v = v | (64'(ref_mem[a+k]) << (8*k));
                        if (!req_unsigned && v[8*nb-1]) v = v | ~((64'd1 << (8*nb)) - 64'd1);
                        resp_val = v[31:0];
                        resp_tag = req_rd;
                        resp_cyc = cyc + L + 1;
                        free_at  = cyc + L + 1;
                    end
                end
            end
        end
    end

    logic        cap_en;
    logic [3:0]  cap_we;
    logic [31:0] cap_addr, cap_wdata, cap_data;
    logic [4:0]  cap_rd;

    // Present a request and hold it until accepted; returns at posedge+1 after acceptance.
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] rd, output int acc_cyc);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd; req_rd = rd;
        acc_cyc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin
                acc_cyc = cyc; cap_en = dm_en; cap_we = dm_we;
                cap_addr = dm_addr; cap_wdata = dm_wdata;
                break;
            end
        end
        if (acc_cyc < 0) begin
            n_tests++; n_fail++;
            $display("FAIL accept_timeout: request at addr 0x%0h not accepted in 20 cycles", addr);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int rc);
        rc = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                rc = cyc; cap_data = resp_data; cap_rd = resp_rd;
                break;
            end
        end
        if (rc < 0) begin
            n_tests++; n_fail++;
            $display("FAIL resp_timeout: no resp_valid within 12 cycles");
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t2, rc, seen, r, gap;
        logic [1:0]  sz;
        logic [31:0] addr;
        @(posedge clk); #1;
        chk_en = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h10;
        @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_dm_en", dm_en, 0);
        chk("rst_dm_we", dm_we, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, 0);
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        @(posedge clk); #1;

        issue(1'b1, 2'd0, 1'b0, 32'h103, 32'h000000A5, 5'd0, t);
        chk("d036_en", cap_en, 1);
        chk("d036_we", cap_we, 4'b1000);
        chk("d036_addr", cap_addr, 32'h100);
        chk("d036_wdata", cap_wdata, 32'hA5A5A5A5);
        @(negedge clk);
        chk("d036_ready_next", req_ready, 1);
        @(posedge clk); #1;

        issue(1'b1, 2'd2, 1'b0, 32'h100, 32'h80011234, 5'd0, t);
        issue(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 5'd7, t);
        wait_resp(rc);
        chk("d037_latency", rc - t, 3);
        chk("d037_data", cap_data, 32'hFFFF8001);
        chk("d037_rd", cap_rd, 7);

        issue(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 5'd9, t);
        wait_resp(rc);
        chk("d038_latency", rc - t, 3);
        chk("d038_data", cap_data, 32'h00000080);

        issue(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 5'd3, t);
        chk("d039_en", cap_en, 0);
        @(negedge clk);
        chk("d039_misaligned", misaligned, 1);
        chk("d039_ready", req_ready, 1);
        @(posedge clk); #1;

        issue(1'b0, 2'd2, 1'b1, 32'h100, 32'h0, 5'd1, t);
        issue(1'b0, 2'd0, 1'b0, 32'h100, 32'h0, 5'd2, t2);
        chk("d040_second_accept", t2 - t, 3);
        wait_resp(rc);
        chk("d040_second_resp", rc - t, 6);
        chk("d040_data", cap_data, 32'h00000034);

        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5'd4, t);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("d041_ready", req_ready, 1);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk("d041_no_resp", seen, 0);
        @(posedge clk); #1;

        for (int n = 0; n < 400; n++) begin
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            addr = 32'($urandom_range(0, 511));
            if ($urandom_range(0, 3) != 0) addr = addr & ~(32'(1 << sz) - 32'd1);
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr,
                  32'($urandom), 5'($urandom_range(0, 31)), t);
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end
        repeat (6) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
